rns_to_bin_conv: RTL and testbench

- Reverse converter: takes a 16-bit RNS word {r256, r129} in the same format as the RNS register file ([15:8] = residue mod 256, [7:0] = residue mod 129) and returns the integer X in [0, 33023].
- Sits after the RNS register file and ALU, so results can be written back to the integer register file or to data memory.
- Multi-cycle FSM using mixed-radix conversion with a valid/ready handshake on both sides.
- Complements the integer-to-RNS forward "fit" path in the EX stage.

---
 rtl/rns_pkg.sv | 26 ++
 rtl/rns_to_bin_conv_if.sv | 29 ++
 rtl/rns_mod129_step.sv | 24 ++
 rtl/rns_to_bin_conv.sv | 123 ++++++++++++
 tb/tb_rns_to_bin_conv.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rns_pkg.sv
// rns_pkg: shared constants and types for the {256, 129} RNS datapath.
//   Moduli, the inverse of 256 mod 129, dynamic range, number of modular
//   doublings used to multiply by that inverse, residue field slice
//   positions within a 16-bit RNS word, and the reverse-converter state enum.
package rns_pkg;

  localparam int unsigned RNS_M_HI           = 256;
  localparam int unsigned RNS_M_LO           = 129;
  localparam int unsigned RNS_INV_HI_MOD_LO  = 64;     // 256*64 = 1 mod 129
  localparam int unsigned RNS_DYN_RANGE      = 33024;  // 256*129
  localparam int unsigned RNS_DBL_STEPS      = 6;      // 64 = 2^6

  // Residue field positions within an RNS word: {r256, r129}
  localparam int unsigned RNS_HI_MSB = 15;
  localparam int unsigned RNS_HI_LSB = 8;
  localparam int unsigned RNS_LO_MSB = 7;
  localparam int unsigned RNS_LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIFF,
    DBL,
    OUT
  } rns_state_e;

endpackage

// File: rtl/rns_to_bin_conv_if.sv
// rns_to_bin_conv_if: valid/ready bundle for the RNS-to-binary converter.
//   in_valid/in_ready/rns_in : RNS word input side ({r256, r129})
//   out_valid/out_ready/bin_out/err : converted integer output side
//   slave  modport : the converter
//   master modport : producer/consumer driving the converter
interface rns_to_bin_conv_if #(
  parameter int unsigned RES_W = 8,
  parameter int unsigned OUT_W = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2*RES_W-1:0]   rns_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     bin_out;
  logic                 err;

  modport slave (
    input  in_valid, rns_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

  modport master (
    output in_valid, rns_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/rns_mod129_step.sv
// rns_mod129_step: one combinational modular step modulo 129.
//   x   [8:0] : operand (< 129 when dbl = 1, <= 255 when dbl = 0)
//   dbl       : 1 -> y = (2*x) mod 129, 0 -> y = x reduced by one subtract
//   y   [7:0] : result in [0, 128]
module rns_mod129_step
  import rns_pkg::*;
(
  input  logic [8:0] x,
  input  logic       dbl,
  output logic [7:0] y
);

  localparam logic [8:0] M_LO = 9'(RNS_M_LO);

  logic [8:0] t;
  logic [8:0] s;

  always_comb begin
    t = dbl ? {x[7:0], 1'b0} : x;
    s = t - M_LO;
    y = (t >= M_LO) ? s[7:0] : t[7:0];
  end

endmodule

// File: rtl/rns_to_bin_conv.sv
// rns_to_bin_conv: multi-cycle reverse converter {r256, r129} -> X in [0, 33023]
// using mixed-radix conversion: X = r256 + 256*d,
//   d = ((r129 - r256 mod 129) * 64) mod 129, with *64 as six modular doublings.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : rns_to_bin_conv_if.slave (in_valid/in_ready/rns_in,
//           out_valid/out_ready/bin_out/err)
// Latency: accept edge E0, out_valid rises at E8; one word in flight.
// Optional: `define RNS2BIN_RANGE_CHECK_EN flags r129 >= 129 as illegal
// (bin_out = 0, err = 1); otherwise r129 is reduced silently and err = 0.
module rns_to_bin_conv
  import rns_pkg::*;
#(
  parameter int unsigned RES_W = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  rns_to_bin_conv_if.slave      bus
);

  rns_state_e        state;
  logic [RES_W-1:0]  r256_q;
  logic [RES_W-1:0]  r129_q;
  logic [RES_W-1:0]  d_q;
  logic [2:0]        cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  bin_out_q;

  logic [7:0]        r256_red;
  logic [7:0]        r129_red;
  logic [7:0]        d_next;
  logic [7:0]        diff;

  rns_mod129_step u_red_hi (.x({1'b0, r256_q}), .dbl(1'b0), .y(r256_red));
  rns_mod129_step u_red_lo (.x({1'b0, r129_q}), .dbl(1'b0), .y(r129_red));
  rns_mod129_step u_dbl    (.x({1'b0, d_q}),    .dbl(1'b1), .y(d_next));

  // Both operands are in [0,128]; when negative, 8-bit wraparound of
  // a + 129 - b still lands in [1,128], so no wider intermediate is needed.
  always_comb begin
    diff = '0;
    if (r129_red >= r256_red)
      diff = r129_red - r256_red;
    else
      diff = r129_red + 8'(RNS_M_LO) - r256_red;
  end

`ifdef RNS2BIN_RANGE_CHECK_EN
  logic rng_err_q;
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_out_q   <= '0;
      r256_q      <= '0;
      r129_q      <= '0;
      d_q         <= '0;
      cnt         <= '0;
`ifdef RNS2BIN_RANGE_CHECK_EN
      rng_err_q   <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            r256_q     <= bus.rns_in[RNS_HI_MSB:RNS_HI_LSB];
            r129_q     <= bus.rns_in[RNS_LO_MSB:RNS_LO_LSB];
`ifdef RNS2BIN_RANGE_CHECK_EN
            rng_err_q  <= (bus.rns_in[RNS_LO_MSB:RNS_LO_LSB] >= 8'(RNS_M_LO));
`endif
            in_ready_q <= 1'b0;
            state      <= DIFF;
          end
        end
        DIFF: begin
          d_q   <= diff;
          cnt   <= '0;
          state <= DBL;
        end
        DBL: begin
          d_q <= d_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'(RNS_DBL_STEPS - 1))
            state <= OUT;
        end
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
`ifdef RNS2BIN_RANGE_CHECK_EN
            bin_out_q   <= rng_err_q ? '0 : OUT_W'({d_q, r256_q});
            err_q       <= rng_err_q;
`else
            bin_out_q   <= OUT_W'({d_q, r256_q});
`endif
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bin_out   = bin_out_q;
`ifdef RNS2BIN_RANGE_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_rns_to_bin_conv.sv
// tb_rns_to_bin_conv: directed-vector bench for rns_to_bin_conv.
// Honours RNS2BIN_RANGE_CHECK_EN for the out-of-range r129 vector.
module tb_rns_to_bin_conv;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  rns_to_bin_conv_if #(.RES_W(8), .OUT_W(16)) bus ();

  rns_to_bin_conv #(.RES_W(8), .OUT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a word, wait for acceptance, then for out_valid; check latency,
  // result and err. Leaves out_ready low so the result is still pending.
  task automatic do_conv(input string tag, input logic [15:0] w,
                         input logic [15:0] exp_x, input logic exp_err);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.rns_in   = w;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_acc"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.rns_in   = '0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_val"}, 32'(bus.bin_out), 32'(exp_x));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_ov"},  32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] sweep_x[$];
  logic [15:0] exp_q[$];
  int          total;
  int          got_cnt;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b1;       // coincident with reset: must be ignored
    bus.rns_in    = 16'hE861;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_bin_out",   32'(bus.bin_out),   32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_ignored_ov", 32'(bus.out_valid), 32'd0);
    check("rst_ignored_ir", 32'(bus.in_ready),  32'd1);

    // X = 1000 with backpressure
    do_conv("x1000", 16'hE861, 16'd1000, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_bin_out",   32'(bus.bin_out),   32'd1000);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    release_out("x1000");

    do_conv("x0", 16'h0000, 16'd0, 1'b0);
    release_out("x0");
    do_conv("xmax", 16'hFF80, 16'd33023, 1'b0);
    release_out("xmax");
    do_conv("x300", 16'h2C2A, 16'd300, 1'b0);
    release_out("x300");
`ifdef RNS2BIN_RANGE_CHECK_EN
    do_conv("r129_bad", 16'h00C8, 16'd0, 1'b1);
`else
    do_conv("r129_bad", 16'h00C8, 16'd7424, 1'b0);
`endif
    release_out("r129_bad");

    // Reset in DBL, counter = 3 (edge E5)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.rns_in   = 16'hE861;
    check("mid_acc", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ir", 32'(bus.in_ready),  32'd1);
    check("mid_rst_bo", 32'(bus.bin_out),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_conv("after_rst", 16'h2C2A, 16'd300, 1'b0);
    release_out("after_rst");

    // Sweep: subset of the range plus edges, random out_ready
    for (int unsigned i = 0; i <= 600; i++) sweep_x.push_back(16'(i * 55));
    sweep_x.push_back(16'd33023);
    sweep_x.push_back(16'd128);
    sweep_x.push_back(16'd129);
    sweep_x.push_back(16'd255);
    sweep_x.push_back(16'd256);
    total   = sweep_x.size();
    got_cnt = 0;

    fork
      begin : producer
        for (int k = 0; k < total; k++) begin
          int unsigned x;
          int n;
          logic [7:0] a, b;
          x = 32'(sweep_x[k]);
          a = 8'(x % 256);
          b = 8'(x % 129);
          @(negedge clk);
          bus.in_valid = 1'b1;
          bus.rns_in   = {a, b};
          n = 0;
          while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (!bus.in_ready) check("sweep_acc", 32'(bus.in_ready), 32'd1);
          @(posedge clk);
          exp_q.push_back(sweep_x[k]);
          #1;
          bus.in_valid = 1'b0;
        end
      end
      begin : consumer
        int cyc;
        cyc = 0;
        while (got_cnt < total && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
              check("sweep_extra", 32'(bus.bin_out), 32'hFFFF_FFFF);
            else
              check("sweep_val", 32'(bus.bin_out), 32'(exp_q.pop_front()));
            got_cnt++;
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
      end
    join

    check("sweep_count", 32'(got_cnt), 32'(total));
    check("sweep_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    check("end_in_ready", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
